// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding selects and multi-cycle FSM state type for hazard_ctrl
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/hazard_mc_fsm.sv
// rtl/hazard_mc_fsm.sv - multi-cycle execute interlock: stalls exactly MC_STALL cycles per op
module hazard_mc_fsm
    import hazard_pkg::*;
#(
    parameter int MC_STALL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_start_e,
    output logic mc_stall
);

    localparam int CW = (MC_STALL > 1) ? $clog2(MC_STALL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MC_STALL > 1) ? MC_STALL - 2 : 0);

    mc_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The IDLE cycle that sees the op already stalls, so BUSY covers the remaining MC_STALL-1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mc_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mc_start_e) begin
                    mc_stall = 1'b1;
                    if (MC_STALL == 1) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (cnt == '0) state_nx = DONE;
                else           cnt_nx   = cnt - 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use, control-flush and multi-cycle interlock for the 5-stage pipe
// Optional saturating perf counters built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MC_STALL = 4,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] rs_d,
    input  logic [NUM_SRC*REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      mem_read_e,
    input  logic                      mc_start_e,
    input  logic                      pc_src_e,
    input  logic [REG_AW-1:0]         rd_m,
    input  logic                      reg_write_m,
    input  logic [REG_AW-1:0]         rd_w,
    input  logic                      reg_write_w,
    output logic [2*NUM_SRC-1:0]      forward_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_m,
    output logic                      mc_busy,
    output logic [CNT_W-1:0]          perf_lu,
    output logic [CNT_W-1:0]          perf_mc,
    output logic [CNT_W-1:0]          perf_fl
);

    logic                 mc_stall;
    logic                 lu;
    logic [2*NUM_SRC-1:0] fwd;

    hazard_mc_fsm #(.MC_STALL(MC_STALL)) u_mc_fsm (
        .clk        (clk),
        .rst        (rst),
        .mc_start_e (mc_start_e),
        .mc_stall   (mc_stall)
    );

    always_comb begin
        fwd = '0;
        lu  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_write_m && rd_m != '0 && rd_m == rs_e[i*REG_AW +: REG_AW])
                fwd[2*i +: 2] = FWD_MEM;
            else if (reg_write_w && rd_w != '0 && rd_w == rs_e[i*REG_AW +: REG_AW])
                fwd[2*i +: 2] = FWD_WB;
            else
                fwd[2*i +: 2] = FWD_RF;
            if (rd_e == rs_d[i*REG_AW +: REG_AW]) lu = 1'b1;
        end
        lu = lu && mem_read_e && (rd_e != '0);
    end

    // Priority: multi-cycle interlock, then control flush, then load-use.
    always_comb begin
        forward_e = '0;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        mc_busy   = 1'b0;
        if (!rst) begin
            forward_e = fwd;
            if (mc_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
                mc_busy = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_evt, mc_evt, fl_evt;

    assign lu_evt = lu && !mc_stall && !pc_src_e;
    assign mc_evt = mc_stall;
    assign fl_evt = pc_src_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu <= '0;
            perf_mc <= '0;
            perf_fl <= '0;
        end else begin
            if (lu_evt && perf_lu != '1) perf_lu <= perf_lu + CNT_W'(1);
            if (mc_evt && perf_mc != '1) perf_mc <= perf_mc + CNT_W'(1);
            if (fl_evt && perf_fl != '1) perf_fl <= perf_fl + CNT_W'(1);
        end
    end
`else
    assign perf_lu = '0;
    assign perf_mc = '0;
    assign perf_fl = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl (MC_STALL=4 and MC_STALL=1/CNT_W=2 instances)
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rs_d, rs_e;
    logic [4:0]  rd_e, rd_m, rd_w;
    logic        mem_read_e, mc_start_e, pc_src_e, reg_write_m, reg_write_w;

    logic [3:0]  forward_e, forward_e1;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
    logic        stall_f1, stall_d1, stall_e1, flush_d1, flush_e1, flush_m1, mc_busy1;
    logic [31:0] perf_lu, perf_mc, perf_fl;
    logic [1:0]  perf_lu1, perf_mc1, perf_fl1;

    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .MC_STALL(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rs_e(rs_e), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .forward_e(forward_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .mc_busy(mc_busy),
        .perf_lu(perf_lu), .perf_mc(perf_mc), .perf_fl(perf_fl)
    );

    hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .MC_STALL(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rs_e(rs_e), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .forward_e(forward_e1), .stall_f(stall_f1), .stall_d(stall_d1), .stall_e(stall_e1),
        .flush_d(flush_d1), .flush_e(flush_e1), .flush_m(flush_m1), .mc_busy(mc_busy1),
        .perf_lu(perf_lu1), .perf_mc(perf_mc1), .perf_fl(perf_fl1)
    );

    // {forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy}
    logic [10:0] obs, obs1;
    assign obs  = {forward_e,  stall_f,  stall_d,  stall_e,  flush_d,  flush_e,  flush_m,  mc_busy};
    assign obs1 = {forward_e1, stall_f1, stall_d1, stall_e1, flush_d1, flush_e1, flush_m1, mc_busy1};

    localparam logic [10:0] O_MC = {4'b0000, 7'b1110011};
    localparam logic [10:0] O_LU = {4'b0000, 7'b1100100};
    localparam logic [10:0] O_FL = {4'b0000, 7'b0001100};

    typedef struct {
        logic [9:0]  rs_d;
        logic [9:0]  rs_e;
        logic [4:0]  rd_e;
        logic        mr;
        logic        pc;
        logic [4:0]  rd_m;
        logic        wm;
        logic [4:0]  rd_w;
        logic        ww;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        mem_read_e = 0; mc_start_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    endtask

    logic [10:0] exp_m[5];
    logic [10:0] exp_1[5];
    int          cnt_m, cnt_1;

    initial begin
        vecs[0]  = '{10'd0,          10'd0,          5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 11'd0};
        vecs[1]  = '{10'd0,          {5'd0, 5'd5},   5'd0, 0, 0, 5'd5, 1, 5'd5, 1, {4'b0010, 7'b0}};
        vecs[2]  = '{10'd0,          {5'd0, 5'd5},   5'd0, 0, 0, 5'd5, 0, 5'd5, 1, {4'b0001, 7'b0}};
        vecs[3]  = '{10'd0,          {5'd0, 5'd5},   5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 11'd0};
        vecs[4]  = '{10'd0,          {5'd3, 5'd3},   5'd0, 0, 0, 5'd3, 1, 5'd0, 0, {4'b1010, 7'b0}};
        vecs[5]  = '{10'd0,          {5'd9, 5'd4},   5'd0, 0, 0, 5'd9, 1, 5'd4, 1, {4'b1001, 7'b0}};
        vecs[6]  = '{{5'd7, 5'd1},   10'd0,          5'd7, 1, 0, 5'd0, 0, 5'd0, 0, O_LU};
        vecs[7]  = '{{5'd0, 5'd1},   10'd0,          5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 11'd0};
        vecs[8]  = '{{5'd2, 5'd7},   10'd0,          5'd7, 1, 0, 5'd0, 0, 5'd0, 0, O_LU};
        vecs[9]  = '{{5'd7, 5'd7},   10'd0,          5'd7, 0, 0, 5'd0, 0, 5'd0, 0, 11'd0};
        vecs[10] = '{{5'd7, 5'd1},   10'd0,          5'd7, 1, 1, 5'd0, 0, 5'd0, 0, O_FL};
        vecs[11] = '{10'd0,          10'd0,          5'd0, 0, 1, 5'd0, 0, 5'd0, 0, O_FL};

        // Reset: every output low even with hazards on the inputs.
        idle_inputs();
        rst = 1; rs_e = {5'd0, 5'd5}; rd_m = 5'd5; reg_write_m = 1;
        mc_start_e = 1; pc_src_e = 1;
        @(negedge clk);
        chk("reset_obs", 32'(obs), 32'd0);
        chk("reset_obs_mc1", 32'(obs1), 32'd0);
        tick();
        rst = 0;
        idle_inputs();

        for (int v = 0; v < 12; v++) begin
            rs_d = vecs[v].rs_d; rs_e = vecs[v].rs_e; rd_e = vecs[v].rd_e;
            mem_read_e = vecs[v].mr; pc_src_e = vecs[v].pc;
            rd_m = vecs[v].rd_m; reg_write_m = vecs[v].wm;
            rd_w = vecs[v].rd_w; reg_write_w = vecs[v].ww;
            @(negedge clk);
            chk($sformatf("vec%0d", v), 32'(obs), 32'(vecs[v].exp));
            chk($sformatf("vec%0d_mc1", v), 32'(obs1), 32'(vecs[v].exp));
            tick();
        end

        // mc_start_e held 5 cycles with a load-use pending: the interlock masks lu.
        idle_inputs();
        mc_start_e = 1; mem_read_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        exp_m = '{O_MC, O_MC, O_MC, O_MC, O_LU};
        exp_1 = '{O_MC, O_LU, O_MC, O_LU, O_MC};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("mc_hold_c%0d", c), 32'(obs), 32'(exp_m[c]));
            chk($sformatf("mc1_hold_c%0d", c), 32'(obs1), 32'(exp_1[c]));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("mc_after_idle", 32'(obs), 32'd0);
        chk("mc1_after_idle", 32'(obs1), 32'd0);
        tick();
        tick();

        // Reset during BUSY cycle 2, then a fresh op must stall the full count.
        mc_start_e = 1;
        tick();
        mc_start_e = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("rst_mid_op", 32'(obs), 32'd0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("after_rst", 32'(obs), 32'd0);
        tick();
        mc_start_e = 1;
        cnt_m = 0; cnt_1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (stall_e) cnt_m++;
            if (stall_e1) cnt_1++;
            tick();
            mc_start_e = 0;
        end
        chk("mc_full_count", 32'(cnt_m), 32'd4);
        chk("mc1_single", 32'(cnt_1), 32'd1);

        // Perf counters: 3 lu, one mc op (4 / 1 stalls), 2 then 3 more flushes.
        rst = 1;
        tick();
        rst = 0;
        mem_read_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        mc_start_e = 1;
        tick();
        mc_start_e = 0;
        for (int k = 0; k < 5; k++) tick();
        pc_src_e = 1;
        tick();
        tick();
        pc_src_e = 0;
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu", perf_lu, 32'd3);
        chk("perf_mc", perf_mc, 32'd4);
        chk("perf_fl", perf_fl, 32'd2);
        chk("perf_lu_w2", 32'(perf_lu1), 32'd3);
        chk("perf_mc_w2", 32'(perf_mc1), 32'd1);
`else
        chk("perf_lu_off", perf_lu, 32'd0);
        chk("perf_mc_off", perf_mc, 32'd0);
        chk("perf_fl_off", perf_fl, 32'd0);
`endif
        tick();
        pc_src_e = 1;
        for (int k = 0; k < 3; k++) tick();
        pc_src_e = 0;
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_fl_5", perf_fl, 32'd5);
        chk("perf_fl_sat", 32'(perf_fl1), 32'd3);
`else
        chk("perf_fl_off_w2", 32'(perf_fl1), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
